cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one line-granular memory port between an I-cache (fills only) and a
// D-cache (fills and write-backs). One transaction is outstanding at a time.
// When both sides ask in the same IDLE cycle, the side that was not served
// most recently wins, so two saturating requesters strictly alternate.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   I_mem_read          : I-cache fill request (held until I_mem_ready)
//   I_mem_addr          : I-cache line address
//   I_mem_ready         : one-cycle completion pulse to the I-cache
//   I_mem_rdata         : I-cache fill data (holds last captured value)
//   D_mem_read/_write   : D-cache fill / write-back request (held until ready)
//   D_mem_addr/_wdata   : D-cache line address / write-back data
//   D_mem_ready         : one-cycle completion pulse to the D-cache
//   D_mem_rdata         : D-cache fill data (holds last captured value)
//   mem_read/mem_write  : registered request to shared memory
//   mem_addr/mem_wdata  : registered request fields, stable until mem_ready
//   mem_ready/mem_rdata : memory completion pulse and its data
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              I_mem_read,
    input  logic [ADDR_W-1:0] I_mem_addr,
    output logic              I_mem_ready,
    output logic [DATA_W-1:0] I_mem_rdata,

    input  logic              D_mem_read,
    input  logic              D_mem_write,
    input  logic [ADDR_W-1:0] D_mem_addr,
    input  logic [DATA_W-1:0] D_mem_wdata,
    output logic              D_mem_ready,
    output logic [DATA_W-1:0] D_mem_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } state_e;

    // Memory-side request, latched whole at grant time.
    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mreq_t;

    state_e            state_q,  state_d;
    mreq_t             mreq_q,   mreq_d;
    logic              last_d_q, last_d_d;   // 1: D was served most recently
    logic              resp_d_q, resp_d_d;   // 1: current RESP belongs to D
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic d_pend;
    logic grant_d;

    assign d_pend  = D_mem_read | D_mem_write;
    // D wins if it is alone, or on a tie when I had the previous turn.
    assign grant_d = d_pend & (~I_mem_read | ~last_d_q);

    always_comb begin
        state_d   = state_q;
        mreq_d    = mreq_q;
        last_d_d  = last_d_q;
        resp_d_d  = resp_d_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d      = SERVE_D;
                    // A simultaneous read+write is treated as a write-back.
                    mreq_d.wr    = D_mem_write;
                    mreq_d.rd    = ~D_mem_write;
                    mreq_d.addr  = D_mem_addr;
                    mreq_d.wdata = D_mem_wdata;
                end else if (I_mem_read) begin
                    state_d      = SERVE_I;
                    mreq_d.rd    = 1'b1;
                    mreq_d.wr    = 1'b0;
                    mreq_d.addr  = I_mem_addr;
                    mreq_d.wdata = '0;
                end
            end

            SERVE_I: begin
                if (mem_ready) begin
                    state_d   = RESP;
                    mreq_d.rd = 1'b0;
                    mreq_d.wr = 1'b0;
                    i_rdata_d = mem_rdata;
                    last_d_d  = 1'b0;
                    resp_d_d  = 1'b0;
                end
            end

            SERVE_D: begin
                if (mem_ready) begin
                    state_d   = RESP;
                    mreq_d.rd = 1'b0;
                    mreq_d.wr = 1'b0;
                    d_rdata_d = mem_rdata;
                    last_d_d  = 1'b1;
                    resp_d_d  = 1'b1;
                end
            end

            // Single-cycle pulse; requests are deliberately not looked at
            // here so a request still held during the pulse is not re-granted.
            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mreq_q    <= '0;
            last_d_q  <= 1'b0;
            resp_d_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            mreq_q    <= mreq_d;
            last_d_q  <= last_d_d;
            resp_d_q  <= resp_d_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Ready pulses decode straight from registered state, so they vanish
    // the instant reset is asserted.
    assign I_mem_ready = (state_q == RESP) & ~resp_d_q;
    assign D_mem_ready = (state_q == RESP) &  resp_d_q;
    assign I_mem_rdata = i_rdata_q;
    assign D_mem_rdata = d_rdata_q;

    assign mem_read    = mreq_q.rd;
    assign mem_write   = mreq_q.wr;
    assign mem_addr    = mreq_q.addr;
    assign mem_wdata   = mreq_q.wdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          I_mem_read = 1'b0;
  logic [AW-1:0] I_mem_addr = '0;
  logic          I_mem_ready;
  logic [DW-1:0] I_mem_rdata;
  logic          D_mem_read = 1'b0;
  logic          D_mem_write = 1'b0;
  logic [AW-1:0] D_mem_addr = '0;
  logic [DW-1:0] D_mem_wdata = '0;
  logic          D_mem_ready;
  logic [DW-1:0] D_mem_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .I_mem_read(I_mem_read), .I_mem_addr(I_mem_addr),
    .I_mem_ready(I_mem_ready), .I_mem_rdata(I_mem_rdata),
    .D_mem_read(D_mem_read), .D_mem_write(D_mem_write),
    .D_mem_addr(D_mem_addr), .D_mem_wdata(D_mem_wdata),
    .D_mem_ready(D_mem_ready), .D_mem_rdata(D_mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  function automatic logic [DW-1:0] fn(input logic [AW-1:0] a);
    return {4{4'hC, a}};
  endfunction

  // memory model: mem_ready `lat` cycles after the request first appears
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } log_t;
  log_t mlog[$];
  int lat = 3;
  int cnt = 0;

  always @(posedge clk) begin
    #1;
    if (mem_ready) begin
      mem_ready = 1'b0;
      cnt = 0;
    end else if (rst_n && (mem_read || mem_write)) begin
      cnt++;
      if (cnt >= lat) begin
        mem_ready = 1'b1;
        mem_rdata = fn(mem_addr);
        mlog.push_back('{mem_write, mem_addr, mem_wdata});
      end
    end else begin
      cnt = 0;
    end
  end

  // monitor
  int i_pulses = 0, d_pulses = 0, both_cnt = 0, rd_hi = 0;
  logic [31:0] order = '0;  // shift register of served sides, 1 = D

  always @(negedge clk) begin
    if (I_mem_ready) begin i_pulses++; order = {order[30:0], 1'b0}; end
    if (D_mem_ready) begin d_pulses++; order = {order[30:0], 1'b1}; end
    if (I_mem_ready && D_mem_ready) both_cnt++;
    if (mem_read) rd_hi++;
  end

  // driver: caches drop their request once they have seen their ready
  int i_seen = 0, d_seen = 0;
  bit auto_drop = 1'b1;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (i_pulses != i_seen) begin
      i_seen = i_pulses;
      if (auto_drop) I_mem_read = 1'b0;
    end
    if (d_pulses != d_seen) begin
      d_seen = d_pulses;
      if (auto_drop) begin D_mem_read = 1'b0; D_mem_write = 1'b0; end
    end
  endtask

  task automatic wait_done(input int ti, input int td, input int budget, input string tag);
    int n;
    n = 0;
    while ((i_pulses < ti || d_pulses < td) && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, "_timeout"}, (i_pulses < ti || d_pulses < td), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int base_i, base_d, base_rd;
  logic [DW-1:0] wd;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_read",  mem_read,    1'b0);
    chk("rst_mem_write", mem_write,   1'b0);
    chk("rst_I_ready",   I_mem_ready, 1'b0);
    chk("rst_D_ready",   D_mem_ready, 1'b0);
    chk("rst_mem_addr",  mem_addr,    '0);
    chk("rst_mem_wdata", mem_wdata,   '0);
    chk("rst_I_rdata",   I_mem_rdata, '0);
    chk("rst_D_rdata",   D_mem_rdata, '0);
    rst_n = 1'b1;

    // I-only read, latency 3, cycle-exact
    cyc();
    I_mem_read = 1'b1; I_mem_addr = 28'h0000010;
    @(negedge clk); chk("i_t0_mem_read", mem_read, 1'b0);
    cyc(); @(negedge clk);
    chk("i_t1_mem_read", mem_read, 1'b1);
    chk("i_t1_mem_addr", mem_addr, 28'h0000010);
    chk("i_t1_mem_write", mem_write, 1'b0);
    cyc(); @(negedge clk);
    chk("i_t2_mem_read", mem_read, 1'b1);
    chk("i_t2_I_ready", I_mem_ready, 1'b0);
    cyc(); @(negedge clk);
    chk("i_t3_mem_ready", mem_ready, 1'b1);
    chk("i_t3_I_ready", I_mem_ready, 1'b0);
    cyc(); @(negedge clk);
    chk("i_t4_I_ready", I_mem_ready, 1'b1);
    chk("i_t4_I_rdata", I_mem_rdata, fn(28'h0000010));
    chk("i_t4_mem_read", mem_read, 1'b0);
    chk("i_t4_D_ready", D_mem_ready, 1'b0);
    cyc(); @(negedge clk);
    chk("i_t5_I_ready", I_mem_ready, 1'b0);
    repeat (3) cyc();
    @(negedge clk);
    chk("i_hold_rdata", I_mem_rdata, fn(28'h0000010));
    chk("i_no_regrant", mem_read, 1'b0);
    chk("i_pulse_cnt", i_pulses, 1);

    // tie right after reset: D first, then I
    do_reset();
    mlog.delete();
    base_i = i_pulses; base_d = d_pulses;
    cyc();
    I_mem_read = 1'b1; I_mem_addr = 28'h0000040;
    D_mem_read = 1'b1; D_mem_addr = 28'h0000030;
    wait_done(base_i + 1, base_d + 1, 40, "tie");
    chk("tie_order", order[1:0], 2'b10);
    chk("tie_log_size", mlog.size(), 2);
    if (mlog.size() >= 2) begin
      chk("tie_first_addr", mlog[0].addr, 28'h0000030);
      chk("tie_second_addr", mlog[1].addr, 28'h0000040);
      chk("tie_second_rd", mlog[1].wr, 1'b0);
    end

    // D write-back
    repeat (2) cyc();
    mlog.delete();
    base_d = d_pulses; base_rd = rd_hi;
    wd = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    D_mem_write = 1'b1; D_mem_addr = 28'h0000020; D_mem_wdata = wd;
    wait_done(0, base_d + 1, 40, "dwr");
    chk("dwr_no_read", rd_hi - base_rd, 0);
    chk("dwr_log_size", mlog.size(), 1);
    if (mlog.size() >= 1) begin
      chk("dwr_is_write", mlog[0].wr, 1'b1);
      chk("dwr_addr", mlog[0].addr, 28'h0000020);
      chk("dwr_wdata", mlog[0].wdata, wd);
    end

    // read+write together is a write
    repeat (2) cyc();
    mlog.delete();
    base_d = d_pulses; base_rd = rd_hi;
    D_mem_read = 1'b1; D_mem_write = 1'b1; D_mem_addr = 28'h0000028;
    wait_done(0, base_d + 1, 40, "drw");
    chk("drw_no_read", rd_hi - base_rd, 0);
    if (mlog.size() >= 1) chk("drw_is_write", mlog[0].wr, 1'b1);
    else chk("drw_log_size", mlog.size(), 1);

    // continuous requests: strict alternation from reset
    do_reset();
    lat = 2;
    auto_drop = 1'b0;
    base_i = i_pulses; base_d = d_pulses;
    cyc();
    I_mem_read = 1'b1; I_mem_addr = 28'h0000070;
    D_mem_read = 1'b1; D_mem_addr = 28'h0000060;
    wait_done(base_i + 3, base_d + 3, 100, "alt");
    I_mem_read = 1'b0; D_mem_read = 1'b0;
    auto_drop = 1'b1;
    chk("alt_order", order[5:0], 6'b101010);
    chk("alt_never_both", both_cnt, 0);
    repeat (6) cyc();
    chk("alt_no_extra", (i_pulses - base_i) + (d_pulses - base_d), 6);

    // D arriving while I is in service waits
    lat = 5;
    mlog.delete();
    base_d = d_pulses;
    cyc();
    I_mem_read = 1'b1; I_mem_addr = 28'h0000080;
    cyc();
    cyc();
    D_mem_read = 1'b1; D_mem_addr = 28'h0000090;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("wait_addr_%0d", k), mem_addr, 28'h0000080);
      chk($sformatf("wait_D_ready_%0d", k), D_mem_ready, 1'b0);
      cyc();
    end
    @(negedge clk);
    chk("wait_I_ready", I_mem_ready, 1'b1);
    chk("wait_D_ready_resp", D_mem_ready, 1'b0);
    wait_done(0, base_d + 1, 40, "wait_d");
    if (mlog.size() >= 2) chk("wait_d_addr", mlog[1].addr, 28'h0000090);
    else chk("wait_log_size", mlog.size(), 2);

    // reset in the middle of SERVE_D
    lat = 8;
    repeat (2) cyc();
    mlog.delete();
    D_mem_read = 1'b1; D_mem_addr = 28'h00000A0;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_mid_serving", mem_read, 1'b1);
    base_d = d_pulses;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_read", mem_read, 1'b0);
    chk("rst_mid_mem_addr", mem_addr, '0);
    chk("rst_mid_D_ready", D_mem_ready, 1'b0);
    chk("rst_mid_D_rdata", D_mem_rdata, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_no_pulse", d_pulses - base_d, 0);
    wait_done(0, base_d + 1, 40, "rst_regrant");
    chk("rst_regrant_rdata", D_mem_rdata, fn(28'h00000A0));
    chk("rst_regrant_once", d_pulses - base_d, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
